// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter with grant/accept handshake; optional WRR_ARB_LOCK_EN adds a lock input.
// Latency: request to grant 1 cycle, accept to next grant 1 cycle (one grant per cycle sustained).
// Backpressure: grant is held stable while gnt_ready is low and the owner keeps requesting.
module wrr_arbiter #(
    parameter int N        = 4,
    parameter int WEIGHT_W = 3,
    parameter int IDX_W    = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N-1:0]          req,
    input  logic [N*WEIGHT_W-1:0] weight,
    input  logic                  gnt_ready,
`ifdef WRR_ARB_LOCK_EN
    input  logic                  lock,
`endif
    output logic [N-1:0]          grant,
    output logic                  gnt_valid,
    output logic [IDX_W-1:0]      gnt_idx
);

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [N-1:0]          r_grant;
    logic [N-1:0]          w_grant_nxt;
    logic [IDX_W-1:0]      r_idx;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic [IDX_W-1:0]      r_ptr;
    logic [IDX_W-1:0]      w_ptr_nxt;
    logic [WEIGHT_W-1:0]   r_credit;
    logic [WEIGHT_W-1:0]   w_credit_nxt;

    logic [WEIGHT_W-1:0]   w_weight [N];
    logic                  w_scan_found;
    logic [IDX_W-1:0]      w_scan_idx;
    logic [IDX_W-1:0]      w_cand;
    logic                  w_keep;
    logic [IDX_W-1:0]      w_win;
    logic [N-1:0]          w_win_oh;
    logic [WEIGHT_W-1:0]   w_credit_arb;
    logic                  w_any_req;
    logic                  w_owner_req;
    logic                  w_lock;

`ifdef WRR_ARB_LOCK_EN
    assign w_lock = lock;
`else
    assign w_lock = 1'b0;
`endif

    for (genvar g = 0; g < N; g++) begin : g_weight
        assign w_weight[g] = weight[g*WEIGHT_W +: WEIGHT_W];
    end

    // Scan starts just past the last owner; the owner itself is the last candidate.
    always_comb begin
        w_scan_found = 1'b0;
        w_scan_idx   = r_ptr;
        w_cand       = '0;
        for (int k = 1; k <= N; k++) begin
            w_cand = IDX_W'((int'(r_ptr) + k) % N);
            if (!w_scan_found && req[w_cand]) begin
                w_scan_found = 1'b1;
                w_scan_idx   = w_cand;
            end
        end
    end

    assign w_any_req    = |req;
    assign w_owner_req  = req[r_idx];
    assign w_keep       = req[r_ptr] && (r_credit != '0);
    assign w_win        = w_keep ? r_ptr : w_scan_idx;
    assign w_credit_arb = w_keep ? (r_credit - WEIGHT_W'(1)) : w_weight[w_scan_idx];
    assign w_win_oh     = {{(N-1){1'b0}}, 1'b1} << w_win;

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_idx_nxt    = r_idx;
        w_ptr_nxt    = r_ptr;
        w_credit_nxt = r_credit;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt  = S_GRANT;
                    w_grant_nxt  = w_win_oh;
                    w_idx_nxt    = w_win;
                    w_ptr_nxt    = w_win;
                    w_credit_nxt = w_credit_arb;
                end
            end
            S_GRANT: begin
                if (gnt_ready) begin
                    if (w_lock && w_owner_req) begin
                        // Locked re-grant: same owner, credit untouched.
                        w_state_nxt = S_GRANT;
                    end else if (w_any_req) begin
                        w_grant_nxt  = w_win_oh;
                        w_idx_nxt    = w_win;
                        w_ptr_nxt    = w_win;
                        w_credit_nxt = w_credit_arb;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_grant_nxt = '0;
                        w_idx_nxt   = '0;
                    end
                end else if (!w_owner_req) begin
                    // Withdrawal forfeits the rest of the turn.
                    w_state_nxt  = S_IDLE;
                    w_grant_nxt  = '0;
                    w_idx_nxt    = '0;
                    w_credit_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
                w_idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_grant  <= '0;
            r_idx    <= '0;
            r_ptr    <= IDX_W'(N-1);
            r_credit <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_idx    <= w_idx_nxt;
            r_ptr    <= w_ptr_nxt;
            r_credit <= w_credit_nxt;
        end
    end

    assign grant     = r_grant;
    assign gnt_valid = |r_grant;
    assign gnt_idx   = r_idx;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed-vector bench for wrr_arbiter (N=4, WEIGHT_W=3); lock sequence runs when WRR_ARB_LOCK_EN is defined.
module tb_wrr_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [11:0] weight;
    logic        gnt_ready;
    logic        lock;
    logic [3:0]  grant;
    logic        gnt_valid;
    logic [1:0]  gnt_idx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wrr_arbiter #(.N(4), .WEIGHT_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .weight    (weight),
        .gnt_ready (gnt_ready),
`ifdef WRR_ARB_LOCK_EN
        .lock      (lock),
`endif
        .grant     (grant),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  rq;
        logic        rdy;
        logic [11:0] wt;
        logic [3:0]  eg;
        logic [1:0]  ei;
    } vec_t;

    vec_t tbl [$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] rq, input logic rdy,
                        input logic [11:0] wt, input logic lk);
        @(negedge clk);
        reset     = r;
        req       = rq;
        gnt_ready = rdy;
        weight    = wt;
        lock      = lk;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [3:0] eg, input logic [1:0] ei);
        logic ev;
        ev = (eg != 4'b0000);
        check({tag, " grant"}, int'(grant), int'(eg));
        check({tag, " idx"}, int'(gnt_idx), int'(ei));
        check({tag, " valid"}, int'(gnt_valid), int'(ev));
        check({tag, " onehot0"}, int'($onehot0(grant)), 1);
    endtask

    int hseq [7] = '{0, 1, 0, 0, 0, 0, 1};

    initial begin
        reset     = 1'b1;
        req       = '0;
        gnt_ready = 1'b0;
        weight    = '0;
        lock      = 1'b0;

        // reset
        tbl.push_back('{1'b1, 4'b0000, 1'b0, 12'h000, 4'b0000, 2'd0});
        // plain round-robin, all weights 0, ready high
        tbl.push_back('{1'b0, 4'b1111, 1'b1, 12'h000, 4'b0001, 2'd0});
        tbl.push_back('{1'b0, 4'b1111, 1'b1, 12'h000, 4'b0010, 2'd1});
        tbl.push_back('{1'b0, 4'b1111, 1'b1, 12'h000, 4'b0100, 2'd2});
        tbl.push_back('{1'b0, 4'b1111, 1'b1, 12'h000, 4'b1000, 2'd3});
        tbl.push_back('{1'b0, 4'b1111, 1'b1, 12'h000, 4'b0001, 2'd0});
        tbl.push_back('{1'b0, 4'b1111, 1'b1, 12'h000, 4'b0010, 2'd1});
        tbl.push_back('{1'b0, 4'b0000, 1'b1, 12'h000, 4'b0000, 2'd0});
        // weight[1]=2, req 0011: 0,1,1,1,0,1,1,1,0
        tbl.push_back('{1'b0, 4'b0011, 1'b1, 12'h010, 4'b0001, 2'd0});
        tbl.push_back('{1'b0, 4'b0011, 1'b1, 12'h010, 4'b0010, 2'd1});
        tbl.push_back('{1'b0, 4'b0011, 1'b1, 12'h010, 4'b0010, 2'd1});
        tbl.push_back('{1'b0, 4'b0011, 1'b1, 12'h010, 4'b0010, 2'd1});
        tbl.push_back('{1'b0, 4'b0011, 1'b1, 12'h010, 4'b0001, 2'd0});
        tbl.push_back('{1'b0, 4'b0011, 1'b1, 12'h010, 4'b0010, 2'd1});
        tbl.push_back('{1'b0, 4'b0011, 1'b1, 12'h010, 4'b0010, 2'd1});
        tbl.push_back('{1'b0, 4'b0011, 1'b1, 12'h010, 4'b0010, 2'd1});
        tbl.push_back('{1'b0, 4'b0011, 1'b1, 12'h010, 4'b0001, 2'd0});
        tbl.push_back('{1'b0, 4'b0000, 1'b1, 12'h010, 4'b0000, 2'd0});
        // stalled grant on requester 2
        tbl.push_back('{1'b0, 4'b0100, 1'b0, 12'h000, 4'b0100, 2'd2});
        for (int i = 0; i < 5; i++)
            tbl.push_back('{1'b0, 4'b0100, 1'b0, 12'h000, 4'b0100, 2'd2});
        tbl.push_back('{1'b0, 4'b0100, 1'b1, 12'h000, 4'b0100, 2'd2});
        tbl.push_back('{1'b0, 4'b0000, 1'b1, 12'h000, 4'b0000, 2'd0});
        tbl.push_back('{1'b0, 4'b0000, 1'b0, 12'h000, 4'b0000, 2'd0});
        // withdrawal of requester 2 while 3 waits
        tbl.push_back('{1'b0, 4'b0100, 1'b0, 12'h000, 4'b0100, 2'd2});
        tbl.push_back('{1'b0, 4'b1000, 1'b0, 12'h000, 4'b0000, 2'd0});
        tbl.push_back('{1'b0, 4'b1000, 1'b0, 12'h000, 4'b1000, 2'd3});
        tbl.push_back('{1'b0, 4'b1000, 1'b1, 12'h000, 4'b1000, 2'd3});
        // reset mid-grant with req 1010
        tbl.push_back('{1'b0, 4'b1010, 1'b0, 12'h000, 4'b1000, 2'd3});
        tbl.push_back('{1'b1, 4'b1010, 1'b0, 12'h000, 4'b0000, 2'd0});
        tbl.push_back('{1'b0, 4'b1010, 1'b0, 12'h000, 4'b0010, 2'd1});
        tbl.push_back('{1'b0, 4'b1010, 1'b1, 12'h000, 4'b1000, 2'd3});
        tbl.push_back('{1'b0, 4'b1010, 1'b1, 12'h000, 4'b0010, 2'd1});
        // accept and withdrawal together counts as accept
        tbl.push_back('{1'b0, 4'b1000, 1'b1, 12'h000, 4'b1000, 2'd3});
        tbl.push_back('{1'b0, 4'b0000, 1'b1, 12'h000, 4'b0000, 2'd0});

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].rq, tbl[i].rdy, tbl[i].wt, 1'b0);
            check_out($sformatf("row%0d", i), tbl[i].eg, tbl[i].ei);
        end

        // Weight change mid-turn: old weight finishes the turn, new one applies at rotation.
        step(1'b0, 4'b0001, 1'b1, 12'h001, 1'b0);
        check_out("wchg start", 4'b0001, 2'd0);
        for (int i = 0; i < 7; i++) begin
            logic [1:0] ei;
            logic [3:0] eg;
            step(1'b0, 4'b0011, 1'b1, 12'h003, 1'b0);
            ei = 2'(hseq[i]);
            eg = 4'b0001 << ei;
            check_out($sformatf("wchg%0d", i), eg, ei);
        end

`ifdef WRR_ARB_LOCK_EN
        step(1'b1, 4'b0000, 1'b0, 12'h000, 1'b0);
        check_out("lock reset", 4'b0000, 2'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 4'b0011, 1'b1, 12'h000, 1'b1);
            check_out($sformatf("lock%0d", i), 4'b0001, 2'd0);
        end
        step(1'b0, 4'b0011, 1'b1, 12'h000, 1'b0);
        check_out("unlock", 4'b0010, 2'd1);
`endif

        step(1'b0, 4'b0000, 1'b1, 12'h000, 1'b0);
        check_out("final idle", 4'b0000, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
